// File: rtl/sync_debounce_if.sv
// Signal bundle between the synchroniser-side driver and the debounce filter.
// The master drives the sampled level and enable; the slave returns the filtered level and pulses.
interface sync_debounce_if;
    logic en_i;
    logic dat_i;
    logic dat_o;
    logic rise_o;
    logic fall_o;
    logic pend_o;

    modport master (
        output en_i, dat_i,
        input  dat_o, rise_o, fall_o, pend_o
    );

    modport slave (
        input  en_i, dat_i,
        output dat_o, rise_o, fall_o, pend_o
    );
endinterface

// File: rtl/sync_debounce.sv
// Debounce filter for an already-synchronised level: a new level is accepted only after
// holding for STABLE_CYC consecutive enabled cycles, with one-cycle rise/fall pulses.
module sync_debounce #(
    parameter int   STABLE_CYC = 16,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    sync_debounce_if.slave  bus
);
    localparam int CNT_WIDTH = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYC - 1);

    typedef enum logic {IDLE, CHK} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 dat, dat_nxt;
    logic                 rise, rise_nxt;
    logic                 fall, fall_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            dat   <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dat   <= dat_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // A disabled cycle freezes timing progress but still clears any pending pulse.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dat_nxt   = dat;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (bus.en_i) begin
            if (bus.dat_i == dat) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                dat_nxt   = bus.dat_i;
                rise_nxt  = bus.dat_i;
                fall_nxt  = ~bus.dat_i;
            end else begin
                state_nxt = CHK;
                cnt_nxt   = cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.dat_o  = dat;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;
    assign bus.pend_o = (cnt != '0);
endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: STABLE_CYC=4 instance plus a STABLE_CYC=1 instance,
// expected {dat,rise,fall,pend} vectors queued per edge and checked by a monitor.
module tb_sync_debounce;
    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    sync_debounce_if bus4 ();
    sync_debounce_if bus1 ();

    sync_debounce #(.STABLE_CYC(4), .RST_VAL(1'b0)) dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (bus4)
    );

    sync_debounce #(.STABLE_CYC(1), .RST_VAL(1'b0)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1)
    );

    typedef struct {
        logic [3:0] exp;
        string      name;
    } item_t;

    item_t q4[$];
    item_t q1[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Monitor: outputs are registered, so sampling on the falling edge is race-free.
    always @(negedge clk) begin
        logic [3:0] act;
        item_t it;
        if (q4.size() > 0) begin
            it  = q4.pop_front();
            act = {bus4.dat_o, bus4.rise_o, bus4.fall_o, bus4.pend_o};
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s (S4): got dat/rise/fall/pend=%b expected %b", it.name, act, it.exp);
            end
        end
        if (q1.size() > 0) begin
            it  = q1.pop_front();
            act = {bus1.dat_o, bus1.rise_o, bus1.fall_o, bus1.pend_o};
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s (S1): got dat/rise/fall/pend=%b expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic step4(input logic r, input logic en, input logic d,
                         input logic [3:0] exp, input string name);
        item_t it;
        @(negedge clk);
        rst4       = r;
        bus4.en_i  = en;
        bus4.dat_i = d;
        @(posedge clk);
        #1;
        it.exp  = exp;
        it.name = name;
        q4.push_back(it);
    endtask

    task automatic step1(input logic r, input logic en, input logic d,
                         input logic [3:0] exp, input string name);
        item_t it;
        @(negedge clk);
        rst1       = r;
        bus1.en_i  = en;
        bus1.dat_i = d;
        @(posedge clk);
        #1;
        it.exp  = exp;
        it.name = name;
        q1.push_back(it);
    endtask

    initial begin
        bus4.en_i  = 1'b1;
        bus4.dat_i = 1'b1;
        bus1.en_i  = 1'b0;
        bus1.dat_i = 1'b0;

        // Reset holds the output low even with the input high.
        repeat (3) step4(1, 1, 1, 4'b0000, "reset");

        // Rising edge accepted on the 4th enabled edge.
        step4(0, 1, 1, 4'b0001, "rise_e1");
        step4(0, 1, 1, 4'b0001, "rise_e2");
        step4(0, 1, 1, 4'b0001, "rise_e3");
        step4(0, 1, 1, 4'b1100, "rise_e4");
        step4(0, 1, 1, 4'b1000, "rise_e5");

        // Falling edge from dat_o=1.
        step4(0, 1, 0, 4'b1001, "fall_e1");
        step4(0, 1, 0, 4'b1001, "fall_e2");
        step4(0, 1, 0, 4'b1001, "fall_e3");
        step4(0, 1, 0, 4'b0010, "fall_e4");
        step4(0, 1, 0, 4'b0000, "fall_e5");

        // Glitch of 3 edges is discarded.
        step4(0, 1, 1, 4'b0001, "glitch_e1");
        step4(0, 1, 1, 4'b0001, "glitch_e2");
        step4(0, 1, 1, 4'b0001, "glitch_e3");
        step4(0, 1, 0, 4'b0000, "glitch_drop");
        step4(0, 1, 0, 4'b0000, "glitch_idle");

        // Disabled cycles freeze the count without breaking consecutiveness.
        step4(0, 1, 1, 4'b0001, "en_e1");
        step4(0, 1, 1, 4'b0001, "en_e2");
        repeat (5) step4(0, 0, 1, 4'b0001, "en_hold");
        step4(0, 1, 1, 4'b0001, "en_e8");
        step4(0, 1, 1, 4'b1100, "en_e9");
        step4(0, 1, 1, 4'b1000, "en_after");

        // Return low, then reset mid-count discards progress.
        step4(0, 1, 0, 4'b1001, "fall2_e1");
        step4(0, 1, 0, 4'b1001, "fall2_e2");
        step4(0, 1, 0, 4'b1001, "fall2_e3");
        step4(0, 1, 0, 4'b0010, "fall2_e4");
        step4(0, 1, 0, 4'b0000, "fall2_e5");
        step4(0, 1, 1, 4'b0001, "midrst_e1");
        step4(0, 1, 1, 4'b0001, "midrst_e2");
        step4(0, 1, 1, 4'b0001, "midrst_e3");
        step4(1, 1, 1, 4'b0000, "midrst_rst");
        step4(0, 1, 1, 4'b0001, "post_e1");
        step4(0, 1, 1, 4'b0001, "post_e2");
        step4(0, 1, 1, 4'b0001, "post_e3");
        step4(0, 1, 1, 4'b1100, "post_e4");
        step4(0, 1, 1, 4'b1000, "post_e5");

        // STABLE_CYC=1: behaves as a plain enabled register with edge pulses.
        step1(1, 1, 0, 4'b0000, "s1_reset");
        step1(0, 1, 1, 4'b1100, "s1_rise");
        step1(0, 1, 1, 4'b1000, "s1_hold");
        step1(0, 1, 0, 4'b0010, "s1_fall");
        step1(0, 1, 0, 4'b0000, "s1_low");
        step1(0, 0, 1, 4'b0000, "s1_frozen");

        repeat (3) @(negedge clk);
        #1;
        if (q4.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d items left expected 0/0", q4.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
